// File: rtl/vx_icache_obi_pipelined_bridge.sv
// Pipelined Vortex I-cache to OBI read bridge: up to MAX_OUTSTANDING fetches in flight, responses in request order.
// Latency: VX handshake -> OBI request next cycle -> response visible the cycle after rvalid; credit-limited backpressure.

module vx_icache_obi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  // Callers never push into a full FIFO without a simultaneous pop, nor pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  assign empty    = (count == '0);
  assign head_dat = empty ? '0 : mem[rptr];
endmodule

module vx_icache_obi_pipelined_bridge #(
  parameter int TAG_WIDTH_BIT   = 1,
  parameter int ADDR_WIDTH      = 30,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     vx_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]                    vx_req_addr_i,
  input  logic [TAG_WIDTH_BIT-1:0]                 vx_req_tag_i,
  output logic                                     vx_req_ready_o,
  output logic                                     vx_rsp_valid_o,
  output logic [31:0]                              vx_rsp_data_o,
  output logic [TAG_WIDTH_BIT-1:0]                 vx_rsp_tag_o,
  input  logic                                     vx_rsp_ready_i,
  output logic                                     obi_req_o,
  input  logic                                     obi_gnt_i,
  output logic [31:0]                              obi_addr_o,
  output logic                                     obi_we_o,
  output logic [3:0]                               obi_be_o,
  output logic [31:0]                              obi_wdata_o,
  input  logic                                     obi_rvalid_i,
  input  logic [31:0]                              obi_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     err_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [TAG_WIDTH_BIT-1:0] tag;
    logic [31:0]              data;
  } rsp_t;

  logic                     valid_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [TAG_WIDTH_BIT-1:0] tag_q;
  logic [CW-1:0]            cnt;
  logic                     err_q;
  logic                     req_hs;
  logic                     obi_hs;
  logic                     rsp_hs;
  logic                     rv_ok;
  logic                     tag_empty;
  logic                     rsp_empty;
  logic [TAG_WIDTH_BIT-1:0] tag_head;
  logic [ADDR_WIDTH+1:0]    byte_addr;
  rsp_t                     rsp_in;
  rsp_t                     rsp_head;

  // Ready looks at gnt combinationally so a granted register can be refilled in the same cycle.
  assign vx_req_ready_o = (cnt < MAX_CNT) & (!valid_q | obi_gnt_i);
  assign req_hs         = vx_req_valid_i & vx_req_ready_o;
  assign obi_hs         = valid_q & obi_gnt_i;
  assign rsp_hs         = !rsp_empty & vx_rsp_ready_i;
  assign rv_ok          = obi_rvalid_i & !tag_empty;
  assign rsp_in         = '{tag: tag_head, data: obi_rdata_i};

  vx_icache_obi_fifo #(.WIDTH(TAG_WIDTH_BIT), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk(clk_i), .rst(rst_i), .push(obi_hs), .push_dat(tag_q),
    .pop(rv_ok), .head_dat(tag_head), .empty(tag_empty)
  );

  vx_icache_obi_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk(clk_i), .rst(rst_i), .push(rv_ok), .push_dat(rsp_in),
    .pop(rsp_hs), .head_dat(rsp_head), .empty(rsp_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_hs) begin
        valid_q <= 1'b1;
        addr_q  <= vx_req_addr_i;
        tag_q   <= vx_req_tag_i;
      end else if (obi_hs) begin
        valid_q <= 1'b0;
      end
      case ({req_hs, rsp_hs})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A beat with no fetch awaiting it is dropped and flagged until reset.
      if (obi_rvalid_i & tag_empty) err_q <= 1'b1;
    end
  end

  assign byte_addr      = {addr_q, 2'b00};
  assign obi_req_o      = valid_q;
  assign obi_addr_o     = 32'(byte_addr);
  assign obi_we_o       = 1'b0;
  assign obi_be_o       = 4'hF;
  assign obi_wdata_o    = 32'h0;
  assign vx_rsp_valid_o = !rsp_empty;
  assign vx_rsp_data_o  = rsp_head.data;
  assign vx_rsp_tag_o   = rsp_head.tag;
  assign outstanding_o  = cnt;
  assign err_o          = err_q;
endmodule
